// File: rtl/bus_burst_slave_mem_if.sv
// Shared burst-bus signal bundle; names are from the responder's point of view.
interface bus_burst_slave_mem_if;
    logic        beginTransactionIn;
    logic [31:0] addressDataIn;
    logic        readNotWriteIn;
    logic [7:0]  burstSizeIn;
    logic [3:0]  byteEnablesIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic [31:0] addressDataOut;
    logic        dataValidOut;
    logic        endTransactionOut;
    logic        busyOut;
    logic        busErrorOut;

    modport master (
        output beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        input  addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
    );

    modport slave (
        input  beginTransactionIn, addressDataIn, readNotWriteIn, burstSizeIn,
               byteEnablesIn, dataValidIn, endTransactionIn,
        output addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
    );
endinterface

// File: rtl/bus_burst_slave_mem.sv
// Burst-bus responder backed by a word-addressed SRAM window at BASE_ADDR; BURST_SLAVE_WAIT_EN adds wait states.
// Latency: first read beat 2 cycles after begin is sampled; write beats are stored on the accepting edge.
// Backpressure: busyOut stalls write beats (BURST_SLAVE_WAIT_EN only); all outputs are registered and 0 when idle.
module bus_burst_slave_mem #(
    parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
    parameter int          ADDR_WIDTH = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    bus_burst_slave_mem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ADDR_ONE = 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_SETUP = 3'd1;
    localparam logic [2:0] S_RD_BEAT  = 3'd2;
    localparam logic [2:0] S_RD_END   = 3'd3;
    localparam logic [2:0] S_WR_BEAT  = 3'd4;
    localparam logic [2:0] S_WR_DRAIN = 3'd5;

    logic [31:0]         r_mem [0:DEPTH-1];
    logic [2:0]          r_state;
    logic [ADDR_WIDTH:0] r_addr;
    logic [8:0]          r_beats;
    logic [3:0]          r_be;
    logic [31:0]         r_dout;
    logic                r_dvld;
    logic                r_eot;
    logic                r_err;

    logic w_sel;
    logic w_busy;
    logic w_no_room;
    logic w_wr_take;
    logic w_wr_en;

`ifdef BURST_SLAVE_WAIT_EN
    logic [1:0] r_wcnt;
    logic       r_gap;
    logic       r_busy;
    assign w_busy = r_busy;
`else
    assign w_busy = 1'b0;
`endif

    assign w_sel     = (bus.addressDataIn[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    // The carry bit of the address counter marks a step past the last word.
    assign w_no_room = (r_beats == 9'd0) || r_addr[ADDR_WIDTH];
    assign w_wr_take = (r_state == S_WR_BEAT) && bus.dataValidIn && !w_busy;
    assign w_wr_en   = w_wr_take && !w_no_room;

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_addr[ADDR_WIDTH-1:0]][8*i +: 8] <= bus.addressDataIn[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_beats <= '0;
            r_be    <= '0;
            r_dout  <= '0;
            r_dvld  <= 1'b0;
            r_eot   <= 1'b0;
            r_err   <= 1'b0;
`ifdef BURST_SLAVE_WAIT_EN
            r_wcnt  <= '0;
            r_gap   <= 1'b0;
            r_busy  <= 1'b0;
`endif
        end else begin
            r_dout <= '0;
            r_dvld <= 1'b0;
            r_eot  <= 1'b0;
            r_err  <= 1'b0;
`ifdef BURST_SLAVE_WAIT_EN
            r_busy <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.beginTransactionIn && w_sel) begin
                        r_addr  <= {1'b0, bus.addressDataIn[ADDR_WIDTH+1:2]};
                        r_beats <= {1'b0, bus.burstSizeIn} + 9'd1;
                        r_be    <= bus.byteEnablesIn;
                        r_state <= bus.readNotWriteIn ? S_RD_SETUP : S_WR_BEAT;
`ifdef BURST_SLAVE_WAIT_EN
                        r_wcnt  <= '0;
                        r_gap   <= 1'b0;
`endif
                    end
                end
                S_RD_SETUP, S_RD_BEAT: begin
                    if (r_beats == 9'd0) begin
                        r_eot   <= 1'b1;
                        r_state <= S_RD_END;
                    end else if (r_addr[ADDR_WIDTH]) begin
                        r_eot   <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
`ifdef BURST_SLAVE_WAIT_EN
                    end else if (r_gap) begin
                        r_gap   <= 1'b0;
                        r_state <= S_RD_BEAT;
`endif
                    end else begin
                        r_dout  <= r_mem[r_addr[ADDR_WIDTH-1:0]];
                        r_dvld  <= 1'b1;
                        r_addr  <= r_addr + ADDR_ONE;
                        r_beats <= r_beats - 9'd1;
                        r_state <= S_RD_BEAT;
`ifdef BURST_SLAVE_WAIT_EN
                        r_wcnt  <= r_wcnt + 2'd1;
                        r_gap   <= (r_wcnt == 2'd3);
`endif
                    end
                end
                S_RD_END: begin
                    r_state <= S_IDLE;
                end
                S_WR_BEAT: begin
                    if (w_wr_take) begin
                        if (w_no_room) begin
                            r_err   <= 1'b1;
                            r_state <= bus.endTransactionIn ? S_IDLE : S_WR_DRAIN;
                        end else begin
                            r_addr  <= r_addr + ADDR_ONE;
                            r_beats <= r_beats - 9'd1;
                            if (bus.endTransactionIn) begin
                                r_state <= S_IDLE;
                            end
`ifdef BURST_SLAVE_WAIT_EN
                            r_wcnt  <= r_wcnt + 2'd1;
                            r_busy  <= (r_wcnt == 2'd3) && !bus.endTransactionIn;
`endif
                        end
                    end else if (bus.endTransactionIn) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR_DRAIN: begin
                    if (bus.endTransactionIn) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.addressDataOut    = r_dout;
    assign bus.dataValidOut      = r_dvld;
    assign bus.endTransactionOut = r_eot;
    assign bus.busErrorOut       = r_err;
    assign bus.busyOut           = w_busy;
endmodule

// File: tb/tb_bus_burst_slave_mem.sv
// Scoreboard bench for bus_burst_slave_mem: directed transactions push timed expected outputs,
// a forked monitor pops and compares each output event on the falling clock edge.
module tb_bus_burst_slave_mem;
    typedef struct {
        int          cyc;
        logic        dv;
        logic        eot;
        logic        err;
        logic [31:0] d;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   act_cnt = 0;
    exp_t sb[$];

    bus_burst_slave_mem_if bus_if();

    bus_burst_slave_mem #(
        .BASE_ADDR (32'h5000_0000),
        .ADDR_WIDTH(9)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required completion", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int c, input logic dv, input logic eot, input logic err,
                            input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.dv = dv; e.eot = eot; e.err = err; e.d = d;
        sb.push_back(e);
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && (bus_if.dataValidOut || bus_if.endTransactionOut ||
                          bus_if.busErrorOut || bus_if.addressDataOut != 32'h0)) begin
                act_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output cyc=%0d got dv=%b eot=%b err=%b d=%h required none",
                             cyc, bus_if.dataValidOut, bus_if.endTransactionOut,
                             bus_if.busErrorOut, bus_if.addressDataOut);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.dv !== bus_if.dataValidOut ||
                        e.eot !== bus_if.endTransactionOut || e.err !== bus_if.busErrorOut ||
                        e.d !== bus_if.addressDataOut) begin
                        bad++;
                        $display("FAIL output_event got cyc=%0d dv=%b eot=%b err=%b d=%h required cyc=%0d dv=%b eot=%b err=%b d=%h",
                                 cyc, bus_if.dataValidOut, bus_if.endTransactionOut,
                                 bus_if.busErrorOut, bus_if.addressDataOut,
                                 e.cyc, e.dv, e.eot, e.err, e.d);
                    end
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_outs_zero(input string tag);
        total++;
        if (bus_if.dataValidOut || bus_if.endTransactionOut || bus_if.busErrorOut ||
            bus_if.busyOut || bus_if.addressDataOut != 32'h0) begin
            bad++;
            $display("FAIL %s got dv=%b eot=%b err=%b busy=%b d=%h required all 0", tag,
                     bus_if.dataValidOut, bus_if.endTransactionOut, bus_if.busErrorOut,
                     bus_if.busyOut, bus_if.addressDataOut);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            idle_cycles(1);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got pending=%0d required 0", tag, sb.size());
            sb.delete();
        end
        idle_cycles(2);
    endtask

    task automatic begin_txn(input logic [31:0] a, input logic rnw, input logic [7:0] bs,
                             input logic [3:0] be, output int bc);
        bus_if.beginTransactionIn = 1'b1;
        bus_if.addressDataIn      = a;
        bus_if.readNotWriteIn     = rnw;
        bus_if.burstSizeIn        = bs;
        bus_if.byteEnablesIn      = be;
        bc = cyc;
        idle_cycles(1);
        bus_if.beginTransactionIn = 1'b0;
        bus_if.addressDataIn      = 32'h0;
        bus_if.readNotWriteIn     = 1'b0;
        bus_if.burstSizeIn        = 8'h0;
        bus_if.byteEnablesIn      = 4'h0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, output int c);
        logic acc;
        acc = 1'b0;
        c = cyc;
        bus_if.dataValidIn      = 1'b1;
        bus_if.addressDataIn    = d;
        bus_if.endTransactionIn = last;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = !bus_if.busyOut;
            c = cyc;
            idle_cycles(1);
        end
        bus_if.dataValidIn      = 1'b0;
        bus_if.addressDataIn    = 32'h0;
        bus_if.endTransactionIn = 1'b0;
    endtask

    task automatic end_wr();
        bus_if.endTransactionIn = 1'b1;
        idle_cycles(1);
        bus_if.endTransactionIn = 1'b0;
    endtask

    // Last beat carries endTransactionIn together with the data.
    task automatic write_burst(input logic [31:0] a, input logic [3:0] be, input int n,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] d [4];
        int bc;
        int c;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        begin_txn(a, 1'b0, 8'(n - 1), be, bc);
        for (int k = 0; k < n; k++) send_beat(d[k], k == n - 1, c);
        idle_cycles(1);
    endtask

    task automatic rd_burst(input string tag, input logic [31:0] a, input int nb, input int nvalid,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] d [4];
        int bc;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        begin_txn(a, 1'b1, 8'(nb - 1), 4'hF, bc);
        for (int k = 0; k < nvalid; k++) push_exp(bc + 2 + k, 1'b1, 1'b0, 1'b0, d[k]);
        if (nvalid < nb) push_exp(bc + 2 + nvalid, 1'b0, 1'b1, 1'b1, 32'h0);
        else             push_exp(bc + 2 + nb, 1'b0, 1'b1, 1'b0, 32'h0);
        wait_drain(tag);
    endtask

    initial begin
        int bc;
        int c;
        int a0;
        bus_if.beginTransactionIn = 1'b0;
        bus_if.addressDataIn      = 32'h0;
        bus_if.readNotWriteIn     = 1'b0;
        bus_if.burstSizeIn        = 8'h0;
        bus_if.byteEnablesIn      = 4'h0;
        bus_if.dataValidIn        = 1'b0;
        bus_if.endTransactionIn   = 1'b0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clock);
        #1;
        check_outs_zero("reset_state");
        reset = 1'b1;
        idle_cycles(2);

        // 4-beat write then read back at word 4
        begin_txn(32'h5000_0010, 1'b0, 8'd3, 4'hF, bc);
        send_beat(32'h11, 1'b0, c);
        send_beat(32'h22, 1'b0, c);
        send_beat(32'h33, 1'b0, c);
        send_beat(32'h44, 1'b0, c);
        end_wr();
        idle_cycles(1);
        rd_burst("rd4", 32'h5000_0010, 4, 4, 32'h11, 32'h22, 32'h33, 32'h44);

        // Partial byte-lane write over a zeroed word
        write_burst(32'h5000_0100, 4'hF, 1, 32'h0, 32'h0, 32'h0, 32'h0);
        write_burst(32'h5000_0100, 4'b0101, 1, 32'hAABB_CCDD, 32'h0, 32'h0, 32'h0);
        rd_burst("rd_be", 32'h5000_0100, 1, 1, 32'h00BB_00DD, 32'h0, 32'h0, 32'h0);

        // Read burst overrunning the top of the window
        write_burst(32'h5000_07F8, 4'hF, 2, 32'h0000_0510, 32'h0000_0511, 32'h0, 32'h0);
        rd_burst("rd_overrun", 32'h5000_07F8, 4, 2, 32'h0000_0510, 32'h0000_0511, 32'h0, 32'h0);

        // Out-of-window begin produces nothing; next in-window read works
        a0 = act_cnt;
        begin_txn(32'h6000_0000, 1'b1, 8'd3, 4'hF, bc);
        idle_cycles(10);
        total++;
        if (act_cnt != a0) begin
            bad++;
            $display("FAIL unselected_quiet got events=%0d required 0", act_cnt - a0);
        end
        rd_burst("rd_after_unsel", 32'h5000_0010, 4, 4, 32'h11, 32'h22, 32'h33, 32'h44);

        // Write overflow: 2 declared beats, 3 sent, 4th arrives while draining
        write_burst(32'h5000_0020, 4'hF, 3, 32'hA0, 32'hA1, 32'hA2, 32'h0);
        begin_txn(32'h5000_0020, 1'b0, 8'd1, 4'hF, bc);
        send_beat(32'hB0, 1'b0, c);
        send_beat(32'hB1, 1'b0, c);
        send_beat(32'hB2, 1'b0, c);
        push_exp(c + 1, 1'b0, 1'b0, 1'b1, 32'h0);
        send_beat(32'hB3, 1'b0, c);
        end_wr();
        wait_drain("wr_overflow");
        rd_burst("rd_overflow", 32'h5000_0020, 3, 3, 32'hB0, 32'hB1, 32'hA2, 32'h0);

        // Reset asserted after the first read beat
        begin_txn(32'h5000_0010, 1'b1, 8'd3, 4'hF, bc);
        push_exp(bc + 2, 1'b1, 1'b0, 1'b0, 32'h11);
        idle_cycles(1);
        #6;
        reset = 1'b0;
        #1;
        check_outs_zero("reset_abort");
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL reset_abort_first_beat got pending=%0d required 0", sb.size());
            sb.delete();
        end
        idle_cycles(2);
        reset = 1'b1;
        idle_cycles(2);
        check_outs_zero("post_reset_idle");
        rd_burst("rd_after_reset", 32'h5000_0010, 4, 4, 32'h11, 32'h22, 32'h33, 32'h44);

        idle_cycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_burst_slave_mem.md
Name: bus_burst_slave_mem

Overview:
- Burst-bus responder (slave) backed by a local word-addressed SRAM.
- Answers single and burst read/write transactions issued by bus initiators such as the DMA controller.
- Sits on the shared bus next to the SDRAM controller and serves as a scratch/test memory window.
- All bus outputs are registered and driven to zero when the block is not the active responder, so they can be OR-combined onto the shared bus.

Parameters:
- BASE_ADDR, 32'h5000_0000, byte base address of the window; must be aligned to the window size.
- ADDR_WIDTH, 9, log2 of memory depth in 32-bit words (default 512 words = 2 KiB window).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- beginTransactionIn  in  1  one-cycle start strobe from the initiator.
- addressDataIn  in  32  byte address while beginTransactionIn=1; write data on beats.
- readNotWriteIn  in  1  1=read, 0=write; valid with beginTransactionIn.
- burstSizeIn  in  8  beats minus 1; valid with beginTransactionIn.
- byteEnablesIn  in  4  write byte lanes; valid with beginTransactionIn, applied to all beats.
- dataValidIn  in  1  write beat valid.
- endTransactionIn  in  1  initiator ends a write transaction.
- addressDataOut  out  32  read data; 0 when not valid.
- dataValidOut  out  1  read beat valid.
- endTransactionOut  out  1  slave ends a read transaction or an aborted transaction.
- busyOut  out  1  write back-pressure.
- busErrorOut  out  1  error pulse.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE; memory contents are retained. Reset asserted mid-burst aborts immediately, with no endTransactionOut.
- Selection: on beginTransactionIn, the block is selected iff addressDataIn[31:ADDR_WIDTH+2] equals BASE_ADDR[31:ADDR_WIDTH+2]. The slave latches word address = addr[ADDR_WIDTH+1:2], beats = burstSizeIn+1, byteEnablesIn and readNotWriteIn. addr[1:0] is ignored.
- When not selected, the block stays IDLE and all outputs stay 0.
- States: IDLE, RD_SETUP, RD_BEAT, RD_END, WR_BEAT, WR_DRAIN.
- IDLE -> RD_SETUP (read, selected) or WR_BEAT (write, selected).
- RD_SETUP: one cycle for the synchronous RAM read. The first dataValidOut comes 2 cycles after the cycle in which begin is sampled.
- RD_BEAT:
  - dataValidOut=1 and addressDataOut=mem[addr] on consecutive cycles; address +1 per beat.
  - After the last beat -> RD_END.
  - RD_END: endTransactionOut=1 for one cycle, dataValidOut=0 -> IDLE.
- WR_BEAT:
  - A beat is accepted when dataValidIn=1 and busyOut=0. Each byte lane i is written only if its byteEnable[i]=1; address +1 per accepted beat.
  - endTransactionIn sampled -> IDLE (a short burst is legal).
  - A beat arriving after the beats counter reaches 0 is dropped: busErrorOut pulses 1 cycle, then -> WR_DRAIN.
  - WR_DRAIN: ignores beats until endTransactionIn -> IDLE.
- Window overrun: a burst that steps past word 2^ADDR_WIDTH-1 does not wrap.
  - Read: on the offending beat, dataValidOut=0, busErrorOut=1 and endTransactionOut=1 in the same cycle -> IDLE.
  - Write: that beat is dropped, busErrorOut pulses and the block goes to WR_DRAIN.
- Simultaneous dataValidIn and endTransactionIn: the beat is accepted, then -> IDLE.
- beginTransactionIn while not IDLE: ignored.
- Arithmetic: beats counter is 9 bits, so burstSizeIn=255 gives 256 beats. The address counter is ADDR_WIDTH+1 bits; its carry bit detects overrun.
- Data is stored exactly as carried on the bus, with no byte swap.
- busyOut is 0 at all times unless the optional feature is compiled in.

Optional Feature:
- Macro BURST_SLAVE_WAIT_EN.
- Defined:
  - In WR_BEAT, busyOut asserts for 1 cycle after every 4th accepted beat.
  - In RD_BEAT, one idle cycle (dataValidOut=0) is inserted after every 4th beat.
  - Used to stress initiator back-pressure and gap handling.
- Undefined: busyOut is held at 0 and read beats are back-to-back.

Test Plan:
- Write burst of 4 beats at 0x5000_0010, data 0x11..0x44, BE=4'hF; then read burst of 4 at the same address -> dataValidOut beats 0x11,0x22,0x33,0x44 starting 2 cycles after begin, then endTransactionOut for 1 cycle.
- Single write of 0xAABBCCDD with BE=4'b0101 over 0x00000000, then read back -> 0x00BB00DD.
- Read burst burstSizeIn=3 starting at word 510 (ADDR_WIDTH=9) -> 2 valid beats, then busErrorOut=1 and endTransactionOut=1 in the same cycle, back to IDLE.
- Begin at 0x6000_0000 (outside window) -> no output activity for 10 cycles; a following in-window read succeeds.
- Write with burstSizeIn=1 and 3 beats sent -> 2 beats stored, busErrorOut pulse on the 3rd beat, IDLE after endTransactionIn; memory at the 3rd address unchanged.
- Reset asserted mid read burst -> outputs 0 asynchronously; after release, a read of previously written data returns the correct values.
